// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode values, datapath select encodings, FSM state and
// instruction-class types shared by the multi-cycle control unit.
package ctrl_pkg;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // ALU operand select encodings
    localparam logic [1:0] ALU_IN1_RS1   = 2'd0;
    localparam logic [1:0] ALU_IN1_I_IMM = 2'd1;
    localparam logic [1:0] ALU_IN1_U_IMM = 2'd2;
    localparam logic       ALU_IN2_RS2   = 1'b0;
    localparam logic       ALU_IN2_PC    = 1'b1;

    // Controller state encoding (visible on the state output)
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    // Where an instruction goes after EXEC
    typedef enum logic [1:0] {
        CLS_WB     = 2'd0,  // ALU/jump result written back
        CLS_LOAD   = 2'd1,  // MEM then WB
        CLS_STORE  = 2'd2,  // MEM then retire
        CLS_RETIRE = 2'd3   // retire straight from EXEC
    } instr_class_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode classifier producing the instruction
// class, decode flags, ALU operand selects and the illegal-opcode flag.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    output instr_class_t cls,
    output logic         is_branch,
    output logic         is_jmp,
    output logic         link_reg,
    output logic [1:0]   alu_in1,
    output logic         alu_in2,
    output logic         illegal
);

    // Classify the opcode; unknown opcodes leave every flag cleared
    always_comb begin
        cls       = CLS_WB;
        is_branch = 1'b0;
        is_jmp    = 1'b0;
        link_reg  = 1'b0;
        alu_in1   = ALU_IN1_RS1;
        alu_in2   = ALU_IN2_RS2;
        illegal   = 1'b0;
        case (opcode)
            OPC_LUI:      alu_in1 = ALU_IN1_U_IMM;
            OPC_AUIPC: begin
                alu_in1 = ALU_IN1_U_IMM;
                alu_in2 = ALU_IN2_PC;
            end
            OPC_OP_IMM:   alu_in1 = ALU_IN1_I_IMM;
            OPC_OP:       cls     = CLS_WB;
            OPC_JAL:      is_jmp  = 1'b1;
            OPC_JALR: begin
                is_jmp   = 1'b1;
                link_reg = 1'b1;
                alu_in1  = ALU_IN1_I_IMM;
            end
            OPC_BRANCH: begin
                cls       = CLS_RETIRE;
                is_branch = 1'b1;
            end
            OPC_LOAD: begin
                cls     = CLS_LOAD;
                alu_in1 = ALU_IN1_I_IMM;
            end
            OPC_STORE:    cls = CLS_STORE;
            OPC_MISC_MEM: cls = CLS_RETIRE;
            OPC_SYSTEM:   cls = CLS_RETIRE;
            default:      illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: sequenced FETCH/DECODE/EXEC/MEM/WB control unit for the
// multi-cycle RV32I core, with illegal-opcode and memory-timeout trapping.
// Optional build macro CTRL_PERF_CNT_EN adds cycle_cnt and instret_cnt outputs.
module multicycle_ctrl #(
    parameter int unsigned ALU_LAT     = 1,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        ir_we,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        pc_we,
    output logic        rd_w,
    output logic        is_branch,
    output logic        is_jmp,
    output logic        link_reg,
    output logic [1:0]  alu_in1,
    output logic        alu_in2,
    output logic        illegal,
    output logic        fault,
`ifdef CTRL_PERF_CNT_EN
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt,
`endif
    output logic [2:0]  state
);

    import ctrl_pkg::*;

    localparam int unsigned EXEC_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [EXEC_W-1:0] EXEC_LOAD = EXEC_W'(ALU_LAT - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

    state_t            state_q;
    state_t            state_d;
    instr_class_t      cls_q;
    logic [EXEC_W-1:0] exec_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_hit;
    logic              ir_we_c;
    logic              pc_we_c;
    logic              rd_w_c;

    instr_class_t      dec_cls;
    logic              dec_is_branch;
    logic              dec_is_jmp;
    logic              dec_link_reg;
    logic [1:0]        dec_alu_in1;
    logic              dec_alu_in2;
    logic              dec_illegal;

    ctrl_decode u_decode (
        .opcode    (opcode),
        .cls       (dec_cls),
        .is_branch (dec_is_branch),
        .is_jmp    (dec_is_jmp),
        .link_reg  (dec_link_reg),
        .alu_in1   (dec_alu_in1),
        .alu_in2   (dec_alu_in2),
        .illegal   (dec_illegal)
    );

    // The wait counter is about to reach MEM_TIMEOUT without an ack
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

    // Next-state logic, Moore request outputs and raw strobes
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        ir_we_c  = 1'b0;
        pc_we_c  = 1'b0;
        rd_w_c   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we_c = 1'b1;
                    state_d = ST_DECODE;
                end else if (timeout_hit) begin
                    state_d = ST_TRAP;
                end
            end
            ST_DECODE: state_d = dec_illegal ? ST_TRAP : ST_EXEC;
            ST_EXEC: begin
                if (exec_cnt == '0) begin
                    case (cls_q)
                        CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                        CLS_RETIRE: begin
                            pc_we_c = 1'b1;
                            state_d = ST_FETCH;
                        end
                        default: state_d = ST_WB;
                    endcase
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_q == CLS_STORE);
                if (dmem_ack) begin
                    if (cls_q == CLS_STORE) begin
                        pc_we_c = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_TRAP;
                end
            end
            ST_WB: begin
                rd_w_c  = 1'b1;
                pc_we_c = 1'b1;
                state_d = ST_FETCH;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase
    end

    // Strobes are suppressed in a reset cycle so an abandoned instruction never retires
    assign ir_we = ir_we_c & rst_n;
    assign pc_we = pc_we_c & rst_n;
    assign rd_w  = rd_w_c & rst_n;
    assign state = state_q;

    // State register, EXEC latency counter, ack-wait counter and sticky fault
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_FETCH;
            exec_cnt <= '0;
            wait_cnt <= '0;
            fault    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                exec_cnt <= EXEC_LOAD;
            end else if (state_q == ST_EXEC && exec_cnt != '0) begin
                exec_cnt <= exec_cnt - EXEC_W'(1);
            end
            if (state_d != state_q) begin
                wait_cnt <= '0;
            end else if (MEM_TIMEOUT != 0 && (state_q == ST_FETCH || state_q == ST_MEM)) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (state_d == ST_TRAP) begin
                fault <= 1'b1;
            end
        end
    end

    // Decode flags and selects captured in DECODE, held for the whole instruction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cls_q     <= CLS_WB;
            is_branch <= 1'b0;
            is_jmp    <= 1'b0;
            link_reg  <= 1'b0;
            alu_in1   <= ALU_IN1_RS1;
            alu_in2   <= ALU_IN2_RS2;
            illegal   <= 1'b0;
        end else if (state_q == ST_DECODE) begin
            cls_q     <= dec_cls;
            is_branch <= dec_is_branch;
            is_jmp    <= dec_is_jmp;
            link_reg  <= dec_link_reg;
            alu_in1   <= dec_alu_in1;
            alu_in2   <= dec_alu_in2;
            if (dec_illegal) begin
                illegal <= 1'b1;
            end
        end
    end

`ifdef CTRL_PERF_CNT_EN
    // Free-running performance counters, wrapping modulo 2^32
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state_q != ST_TRAP) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (pc_we) begin
                instret_cnt <= instret_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized instruction stream checked cycle by cycle
// against a transaction-level expectation schedule built from the
// instruction-class rules (fetch wait, decode, EXEC latency, memory wait, WB).
module tb_multicycle_ctrl;

    localparam int unsigned LAT = 3;
    localparam int unsigned TO  = 4;

    localparam int K_WB     = 0;
    localparam int K_LOAD   = 1;
    localparam int K_STORE  = 2;
    localparam int K_RETIRE = 3;
    localparam int K_BAD    = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        imem_req;
    logic        imem_ack;
    logic        ir_we;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        pc_we;
    logic        rd_w;
    logic        is_branch;
    logic        is_jmp;
    logic        link_reg;
    logic [1:0]  alu_in1;
    logic        alu_in2;
    logic        illegal;
    logic        fault;
    logic [2:0]  state;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
`endif

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .ALU_LAT     (LAT),
        .MEM_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .ir_we       (ir_we),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ack    (dmem_ack),
        .pc_we       (pc_we),
        .rd_w        (rd_w),
        .is_branch   (is_branch),
        .is_jmp      (is_jmp),
        .link_reg    (link_reg),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .illegal     (illegal),
        .fault       (fault),
`ifdef CTRL_PERF_CNT_EN
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt),
`endif
        .state       (state)
    );

    // One planned clock cycle: inputs to drive and the expected output word
    typedef struct {
        logic        rst;
        logic        iack;
        logic        dack;
        logic [6:0]  opc;
        logic [16:0] exp;
    } cyc_t;

    cyc_t sched[$];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Architectural view the model keeps between cycles
    logic       m_br, m_jmp, m_link, m_in2, m_ill, m_fault;
    logic [1:0] m_in1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] ro();
        return 7'($urandom());
    endfunction

    function automatic logic [16:0] obs_word();
        return {state, imem_req, ir_we, dmem_req, dmem_we, pc_we, rd_w,
                is_branch, is_jmp, link_reg, alu_in1, alu_in2, illegal, fault};
    endfunction

    // Reference decode table: class of instruction plus the held flags/selects
    task automatic ref_decode(input logic [6:0] opc, output int kind,
                              output logic br, output logic jmp, output logic link,
                              output logic [1:0] in1, output logic in2);
        br = 1'b0; jmp = 1'b0; link = 1'b0; in1 = 2'd0; in2 = 1'b0; kind = K_BAD;
        case (opc)
            7'b0110111: begin kind = K_WB; in1 = 2'd2; end               // LUI
            7'b0010111: begin kind = K_WB; in1 = 2'd2; in2 = 1'b1; end   // AUIPC
            7'b0010011: begin kind = K_WB; in1 = 2'd1; end               // OP-IMM
            7'b0110011: kind = K_WB;                                     // OP
            7'b1101111: begin kind = K_WB; jmp = 1'b1; end               // JAL
            7'b1100111: begin kind = K_WB; jmp = 1'b1; link = 1'b1; in1 = 2'd1; end
            7'b1100011: begin kind = K_RETIRE; br = 1'b1; end            // BRANCH
            7'b0000011: begin kind = K_LOAD; in1 = 2'd1; end             // LOAD
            7'b0100011: kind = K_STORE;                                  // STORE
            7'b0001111: kind = K_RETIRE;                                 // MISC-MEM
            7'b1110011: kind = K_RETIRE;                                 // SYSTEM
            default:    kind = K_BAD;
        endcase
    endtask

    task automatic model_reset();
        m_br = 1'b0; m_jmp = 1'b0; m_link = 1'b0;
        m_in1 = 2'd0; m_in2 = 1'b0; m_ill = 1'b0; m_fault = 1'b0;
    endtask

    task automatic push(input logic [2:0] st, input logic ireq, input logic irwe,
                        input logic dreq, input logic dwe, input logic pcwe, input logic rdw,
                        input logic iack, input logic dack, input logic [6:0] opc, input logic rst);
        cyc_t e;
        e.rst  = rst;
        e.iack = iack;
        e.dack = dack;
        e.opc  = opc;
        e.exp  = {st, ireq, irwe, dreq, dwe, pcwe, rdw,
                  m_br, m_jmp, m_link, m_in1, m_in2, m_ill, m_fault};
        sched.push_back(e);
    endtask

    // Trap: stuck with everything idle, acks ignored, until a reset cycle
    task automatic enter_trap();
        int unsigned n;
        m_fault = 1'b1;
        n = $urandom_range(2, 5);
        for (int unsigned k = 0; k < n; k++)
            push(3'd5, 0, 0, 0, 0, 0, 0, rb(), rb(), ro(), 1'b1);
        push(3'd5, 0, 0, 0, 0, 0, 0, rb(), rb(), ro(), 1'b0);
        model_reset();
    endtask

    // Plan one instruction: iw/dw = idle cycles before the imem/dmem ack,
    // rst_at >= 0 aborts the instruction with reset on that MEM cycle
    task automatic plan_instr(input logic [6:0] opc, input int unsigned iw,
                              input int unsigned dw, input int rst_at);
        int         kind;
        logic       br, jmp, link, in2, st;
        logic [1:0] in1;
        if (TO > 0 && iw >= TO) begin
            for (int unsigned k = 0; k < TO; k++)
                push(3'd0, 1, 0, 0, 0, 0, 0, 1'b0, rb(), ro(), 1'b1);
            enter_trap();
            return;
        end
        for (int unsigned k = 0; k < iw; k++)
            push(3'd0, 1, 0, 0, 0, 0, 0, 1'b0, rb(), ro(), 1'b1);
        push(3'd0, 1, 1, 0, 0, 0, 0, 1'b1, rb(), ro(), 1'b1);
        push(3'd1, 0, 0, 0, 0, 0, 0, rb(), rb(), opc, 1'b1);
        ref_decode(opc, kind, br, jmp, link, in1, in2);
        m_br = br; m_jmp = jmp; m_link = link; m_in1 = in1; m_in2 = in2;
        if (kind == K_BAD) begin
            m_ill = 1'b1;
            enter_trap();
            return;
        end
        for (int unsigned k = 0; k < LAT; k++)
            push(3'd2, 0, 0, 0, 0, (k == LAT - 1) && (kind == K_RETIRE), 0, rb(), rb(), ro(), 1'b1);
        if (kind == K_RETIRE) return;
        if (kind == K_LOAD || kind == K_STORE) begin
            st = (kind == K_STORE);
            if (TO > 0 && dw >= TO) begin
                for (int unsigned k = 0; k < TO; k++)
                    push(3'd3, 0, 0, 1, st, 0, 0, rb(), 1'b0, ro(), 1'b1);
                enter_trap();
                return;
            end
            for (int unsigned k = 0; k < dw; k++) begin
                if (rst_at >= 0 && int'(k) == rst_at) begin
                    push(3'd3, 0, 0, 1, st, 0, 0, 1'b0, 1'b0, ro(), 1'b0);
                    model_reset();
                    return;
                end
                push(3'd3, 0, 0, 1, st, 0, 0, rb(), 1'b0, ro(), 1'b1);
            end
            push(3'd3, 0, 0, 1, st, st, 0, rb(), 1'b1, ro(), 1'b1);
            if (st) return;
        end
        push(3'd4, 0, 0, 0, 0, 1, 1, rb(), rb(), ro(), 1'b1);
    endtask

    function automatic int unsigned pick_wait();
        int unsigned r;
        r = $urandom_range(0, 19);
        if (r == 0) return TO;
        if (r == 1) return TO - 1;
        return $urandom_range(0, 2);
    endfunction

    initial begin
        logic [6:0]  legal_ops [11];
        logic [31:0] exp_cyc;
        logic [31:0] exp_ret;
        legal_ops = '{7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011, 7'b1101111, 7'b1100111,
                      7'b1100011, 7'b0000011, 7'b0100011, 7'b0001111, 7'b1110011};
        model_reset();
        rst_n    = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        opcode   = 7'd0;

        // Directed cases first
        plan_instr(7'b0010011, 2, 0, -1);        // ADDI, ack 2 cycles late
        plan_instr(7'b0000011, 0, 1, -1);        // LW, ack on 2nd MEM cycle
        plan_instr(7'b0100011, 1, 0, -1);        // SW
        plan_instr(7'b0000000, 0, 0, -1);        // illegal opcode -> trap
        plan_instr(7'b0010011, TO, 0, -1);       // fetch timeout
        plan_instr(7'b0010011, TO - 1, 0, -1);   // ack on the last allowed cycle
        plan_instr(7'b0000011, 0, TO, -1);       // data timeout
        plan_instr(7'b0100011, 0, TO - 1, -1);   // store ack on the last allowed cycle
        plan_instr(7'b0000011, 0, TO - 1, 1);    // reset during MEM
        plan_instr(7'b1100011, 0, 0, -1);        // branch after the abandoned load
        // Random stream
        for (int n = 0; n < 160; n++) begin
            logic [6:0] op;
            int         kind;
            logic       b0, b1, b2, b4;
            logic [1:0] b3;
            if ($urandom_range(0, 15) == 0) begin
                op = ro();
                ref_decode(op, kind, b0, b1, b2, b3, b4);
                if (kind != K_BAD) op = 7'b1111111;
            end else begin
                op = legal_ops[$urandom_range(0, 10)];
            end
            plan_instr(op, pick_wait(), pick_wait(), -1);
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("reset", 32'(obs_word()), 32'({3'd0, 1'b1, 13'd0}));
`ifdef CTRL_PERF_CNT_EN
        check_eq("reset_cyc", cycle_cnt, 32'd0);
        check_eq("reset_ret", instret_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;
        exp_cyc = 32'd0;
        exp_ret = 32'd0;

        for (int i = 0; i < sched.size(); i++) begin
            rst_n    = sched[i].rst;
            imem_ack = sched[i].iack;
            dmem_ack = sched[i].dack;
            opcode   = sched[i].opc;
            @(negedge clk);
            check_eq($sformatf("cyc%0d", i), 32'(obs_word()), 32'(sched[i].exp));
`ifdef CTRL_PERF_CNT_EN
            check_eq($sformatf("cycle_cnt%0d", i), cycle_cnt, exp_cyc);
            check_eq($sformatf("instret%0d", i), instret_cnt, exp_ret);
`endif
            @(posedge clk);
            #1;
            if (!sched[i].rst) begin
                exp_cyc = 32'd0;
                exp_ret = 32'd0;
            end else begin
                if (sched[i].exp[16:14] != 3'd5) exp_cyc = exp_cyc + 32'd1;
                if (sched[i].exp[9]) exp_ret = exp_ret + 32'd1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
